// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback always wins, multi-cycle
// unit results wait in a small FIFO and drain whenever the port is otherwise free.
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data,
    output logic [31:0] pending,
    output logic        stall_req,
    output logic        conflict_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [3:0]       LIMIT   = 4'(STARVE_LIMIT);

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;
    logic             wb_grant, head_grant, push, not_empty;
    logic [PTR_W-1:0] idx;

    assign not_empty  = (count_q != '0);
    assign mdu_ready  = (count_q != FULL);
    // Writes to r0 are handshaken but never stored.
    assign push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign wb_grant   = wb_we && (wb_rd != 5'd0);
    assign head_grant = !wb_grant && not_empty;

    assign stall_req    = stall_q;
    assign conflict_err = err_q;

    always_comb begin
        RegWrite       = wb_grant || head_grant;
        Write_register = 5'd0;
        Write_data     = 32'd0;
        if (wb_grant) begin
            Write_register = wb_rd;
            Write_data     = wb_data;
        end else if (head_grant) begin
            Write_register = rd_mem[rd_ptr_q];
            Write_data     = data_mem[rd_ptr_q];
        end
    end

    always_comb begin
        pending = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) pending[rd_mem[idx]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = head_grant ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, head_grant})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Starvation only accumulates while an entry waits behind writeback.
        starve_d = starve_q;
        stall_d  = stall_q;
        if (!not_empty || head_grant) begin
            starve_d = 4'd0;
            stall_d  = 1'b0;
        end else begin
            if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
            if (starve_q == LIMIT) stall_d = 1'b1;
        end

        err_d = err_q || (stall_q && wb_grant);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= mdu_rd;
            data_mem[wr_ptr_q] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] pending;
    logic        stall_req;
    logic        conflict_err;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mdu_valid      (mdu_valid),
        .mdu_rd         (mdu_rd),
        .mdu_data       (mdu_data),
        .mdu_ready      (mdu_ready),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .pending        (pending),
        .stall_req      (stall_req),
        .conflict_err   (conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   m_starve;
    bit   m_stall;
    bit   m_err;
    int   n_vec;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_stall  = 0;
        m_err    = 0;
    endtask

    task automatic check_outputs();
        bit          wbg;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_pend;
        wbg    = wb_we && (wb_rd != 0);
        e_rd   = 0;
        e_data = 0;
        if (wbg) begin
            e_rd   = wb_rd;
            e_data = wb_data;
        end else if (q.size() != 0) begin
            e_rd   = q[0].rd;
            e_data = q[0].data;
        end
        e_pend = 0;
        foreach (q[i]) e_pend[q[i].rd] = 1'b1;
        chk("mdu_ready", 32'(mdu_ready), 32'(q.size() != DEPTH));
        chk("RegWrite", 32'(RegWrite), 32'(wbg || q.size() != 0));
        chk("Write_register", 32'(Write_register), 32'(e_rd));
        chk("Write_data", Write_data, e_data);
        chk("pending", pending, e_pend);
        chk("stall_req", 32'(stall_req), 32'(m_stall));
        chk("conflict_err", 32'(conflict_err), 32'(m_err));
    endtask

    task automatic model_edge();
        bit wbg, pop, acc;
        wbg = wb_we && (wb_rd != 0);
        pop = !wbg && (q.size() != 0);
        acc = mdu_valid && (q.size() != DEPTH) && (mdu_rd != 0);
        if (m_stall && wbg) m_err = 1;
        if (q.size() == 0 || pop) begin
            m_starve = 0;
            m_stall  = 0;
        end else begin
            if (m_starve == LIMIT) m_stall = 1;
            if (m_starve < LIMIT) m_starve++;
        end
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{mdu_rd, mdu_data});
    endtask

    task automatic cyc(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        wb_we     = we;
        wb_rd     = wrd;
        wb_data   = wd;
        mdu_valid = mv;
        mdu_rd    = mrd;
        mdu_data  = md;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        reset     = 1'b1;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        mdu_valid = 1'b0;
        mdu_rd    = 5'd0;
        mdu_data  = 32'd0;
        #7;
        check_outputs();
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_BEEF;
        #1;
        check_outputs();
        wb_we = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single MDU result with the writeback idle
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
        idle(2);

        // Writeback beats a queued entry; the entry follows when writeback idles
        cyc(1'b1, 5'd2, 32'h0000_5555, 1'b1, 5'd7, 32'h0000_0777);
        cyc(1'b1, 5'd3, 32'h0000_AAAA, 1'b0, 5'd0, 32'd0);
        idle(2);

        // r0 results are swallowed; writeback to r0 leaves the port to the FIFO
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_0000);
        cyc(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd9, 32'h0000_0909);
        cyc(1'b1, 5'd0, 32'h0BAD_0BAD, 1'b0, 5'd0, 32'd0);
        idle(1);

        // Busy writeback fills the FIFO, starves it, then drains in order
        cyc(1'b1, 5'd10, 32'h1000_0001, 1'b1, 5'd11, 32'h0000_0B11);
        cyc(1'b1, 5'd10, 32'h1000_0002, 1'b1, 5'd12, 32'h0000_0C12);
        cyc(1'b1, 5'd10, 32'h1000_0003, 1'b1, 5'd13, 32'h0000_0D13);
        for (int i = 0; i < 6; i++) cyc(1'b1, 5'd10, 32'h2000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
        chk("stall_after_starve", 32'(stall_req), 32'd1);
        idle(4);
        chk("conflict_sticky", 32'(conflict_err), 32'd1);

        // Asynchronous reset mid-cycle with two entries queued
        cyc(1'b1, 5'd14, 32'h3000_0001, 1'b1, 5'd15, 32'h0000_0F15);
        cyc(1'b1, 5'd14, 32'h3000_0002, 1'b1, 5'd16, 32'h0000_0F16);
        wb_we     = 1'b0;
        mdu_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("reset_pending", pending, 32'd0);
        #1 reset = 1'b0;
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 6),
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                $urandom,
                1'($urandom),
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                $urandom);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, number of buffered multi-cycle-unit (MDU) write entries; legal values 2, 4, 8.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive blocked cycles after which stall_req asserts; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port wb_we  input  1  pipeline writeback request, always accepted.
REQ-006 The block SHALL have port wb_rd  input  5  writeback destination register.
REQ-007 The block SHALL have port wb_data  input  32  writeback data.
REQ-008 The block SHALL have port mdu_valid  input  1  MDU result offered.
REQ-009 The block SHALL have port mdu_rd  input  5  MDU destination register.
REQ-010 The block SHALL have port mdu_data  input  32  MDU result data.
REQ-011 The block SHALL have port mdu_ready  output  1  high when the buffer can accept an entry this cycle.
REQ-012 The block SHALL have port RegWrite  output  1  register-file write enable.
REQ-013 The block SHALL have port Write_register  output  5  register-file write address.
REQ-014 The block SHALL have port Write_data  output  32  register-file write data.
REQ-015 The block SHALL have port pending  output  32  bit i high while a buffered write to register i is outstanding; bit 0 always 0.
REQ-016 The block SHALL have port stall_req  output  1  registered request to the hazard unit to hold wb_we low.
REQ-017 The block SHALL have port conflict_err  output  1  sticky error flag.

Function
REQ-018 The buffer SHALL be a circular FIFO of DEPTH entries {rd, data} with read/write pointers wrapping modulo DEPTH and an occupancy count of 0..DEPTH.
REQ-019 mdu_ready SHALL equal (count != DEPTH), depending only on registered state; a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-020 A handshake (mdu_valid && mdu_ready) with mdu_rd != 0 SHALL enqueue at the rising edge; a handshake with mdu_rd == 0 SHALL be accepted and discarded.
REQ-021 Grant SHALL be combinational: wb wins when wb_we && wb_rd != 0; otherwise the FIFO head wins when count != 0; otherwise there is no write.
REQ-022 On a wb grant, RegWrite=1, Write_register=wb_rd, and Write_data=wb_data in the same cycle (zero latency).
REQ-023 On a head grant, RegWrite=1 and Write_register/Write_data SHALL equal the head entry, which is popped at the rising edge; minimum MDU enqueue-to-write latency SHALL be 1 cycle, with no bypass from mdu_* to the outputs.
REQ-024 With no grant, RegWrite=0 and Write_register/Write_data=0.
REQ-025 Simultaneous enqueue and pop SHALL leave count unchanged and advance both pointers.
REQ-026 pending SHALL be the OR over valid FIFO entries of the one-hot of rd, computed from registered state.
REQ-027 The starve counter SHALL increment each cycle with count != 0 and the head not granted, clear on any head grant or when count == 0, and saturate at STARVE_LIMIT.
REQ-028 stall_req SHALL be registered high the cycle after the starve counter reaches STARVE_LIMIT, and SHALL be low the cycle after the next head grant or when count reaches 0.
REQ-029 While stall_req=1, wb still SHALL win if wb_we && wb_rd != 0; no wb write is ever dropped, and in that case conflict_err SHALL set and stay set until reset.
REQ-030 wb_we with wb_rd == 0 SHALL produce no write and SHALL NOT block the head.

Reset
REQ-031 Asserting reset SHALL immediately clear pointers, count, starve counter, stall_req and conflict_err, regardless of clk, discarding buffered entries.
REQ-032 While reset is high, mdu_ready=1, RegWrite=0 (unless wb_we && wb_rd != 0), pending=0 and stall_req=0.
REQ-033 Reset asserted mid-operation with entries queued SHALL lose those entries, and no write of them SHALL occur after reset release.

Verification
REQ-034 Idle wb: mdu_valid=1, rd=5, data=0x1234 for one cycle -> next cycle RegWrite=1, Write_register=5, Write_data=0x1234, pending[5]=1 only in the enqueue-to-write cycle, then pending=0.
REQ-035 wb_we=1 rd=3 data=0xAAAA in the same cycle a queued entry rd=7 exists -> wb written that cycle; rd=7 written the first cycle wb_we=0.
REQ-036 DEPTH=2, wb continuously busy, three MDU offers -> two accepted, mdu_ready=0 on the third; stall_req rises 5 cycles after the first enqueue (STARVE_LIMIT=4); after wb_we drops, entries drain in FIFO order.
REQ-037 wb_we held at 1 while stall_req=1 -> wb written, conflict_err=1 and sticky until reset.
REQ-038 mdu_rd=0 accepted -> no RegWrite and pending unchanged; wb_we=1 with wb_rd=0 and queued head rd=9 -> rd=9 written.
REQ-039 Reset pulse mid-clock with 2 entries queued -> outputs immediately at reset values; no write of those entries follows.
